// File: rtl/alu_core_seq.sv
`default_nettype none
// =============================================================================
// Module  : alu_core_seq
// Brief   : 4-bit pushbutton ALU with synchronised keys and a shift-add MUL
//           (MUL and MUL_RUN exist only when ALU_MUL_EN is defined).
// Revision: 1.0 - initial release
// =============================================================================
module alu_core_seq #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  input  logic [2:0] op,
  input  logic       key_load_a,
  input  logic       key_load_b,
  input  logic       key_exec,
  output logic [3:0] aluout,
  output logic [3:0] aluout_hi,
  output logic       carry,
  output logic       zero,
  output logic       err,
  output logic       busy,
  output logic       done
);

  localparam int C_NUM_KEYS = 3;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_EXEC = 2'd1, S_MUL_RUN = 2'd2, S_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd3
  } state_t;
`endif

  state_t                r_state;
  logic [3:0]            r_a, r_b;
  logic [2:0]            r_op;
  logic [SYNC_STAGES-1:0] r_fill;
  logic [C_NUM_KEYS-1:0] w_key_raw, w_key_pulse;
  logic                  w_filled, w_load_a, w_load_b, w_exec;
  logic [4:0]            w_res;

  assign w_key_raw = {key_exec, key_load_b, key_load_a};
  assign w_filled  = r_fill[SYNC_STAGES-1];

  // Marks when the synchroniser outputs hold real samples instead of reset ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fill <= '0;
    else        r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
  end

  for (genvar gi = 0; gi < C_NUM_KEYS; gi++) begin : g_key
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev, r_arm;

    // A key only arms after it has been seen released, so a key held through reset stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= '1;
        r_prev <= 1'b1;
        r_arm  <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_key_raw[gi]};
        r_prev <= r_sync[SYNC_STAGES-1];
        if (w_filled && r_sync[SYNC_STAGES-1]) r_arm <= 1'b1;
      end
    end

    assign w_key_pulse[gi] = r_arm & r_prev & ~r_sync[SYNC_STAGES-1];
  end

  assign w_load_a = w_key_pulse[0];
  assign w_load_b = w_key_pulse[1];
  assign w_exec   = w_key_pulse[2];

  always_comb begin
    w_res = 5'd0;
    case (r_op)
      3'b000:  w_res = {1'b0, r_a} + {1'b0, r_b};
      3'b001:  w_res = {(r_a < r_b), r_a - r_b};
      3'b010:  w_res = {1'b0, r_a & r_b};
      3'b011:  w_res = {1'b0, r_a | r_b};
      3'b100:  w_res = {1'b0, r_a ^ r_b};
      3'b101:  w_res = {1'b0, ~r_a};
      3'b110:  w_res = {r_a[3], r_a[2:0], 1'b0};
      default: w_res = 5'd0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [7:0] r_acc, r_mcand, w_acc_next;
  logic [3:0] r_mplier;
  logic [1:0] r_cnt;
  assign w_acc_next = r_mplier[0] ? r_acc + r_mcand : r_acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= 4'd0;
      r_b       <= 4'd0;
      r_op      <= 3'd0;
      aluout    <= 4'd0;
      aluout_hi <= 4'd0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ALU_MUL_EN
      r_acc     <= 8'd0;
      r_mcand   <= 8'd0;
      r_mplier  <= 4'd0;
      r_cnt     <= 2'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_load_a) r_a <= sw_a;
          if (w_load_b) r_b <= sw_b;
          // A load in the same cycle wins over exec.
          if (w_exec && !w_load_a && !w_load_b) begin
            r_op <= op;
            done <= 1'b0;
            err  <= 1'b0;
            busy <= 1'b1;
`ifdef ALU_MUL_EN
            if (op == 3'b111) begin
              r_state  <= S_MUL_RUN;
              r_acc    <= 8'd0;
              r_mcand  <= {4'd0, r_a};
              r_mplier <= r_b;
              r_cnt    <= 2'd0;
            end else begin
              r_state <= S_EXEC;
            end
`else
            r_state <= S_EXEC;
`endif
          end
        end
        S_EXEC: begin
          aluout    <= w_res[3:0];
          aluout_hi <= 4'd0;
          carry     <= w_res[4];
          zero      <= (w_res[3:0] == 4'd0);
`ifndef ALU_MUL_EN
          err       <= (r_op == 3'b111);
`endif
          busy      <= 1'b0;
          done      <= 1'b1;
          r_state   <= S_DONE;
        end
`ifdef ALU_MUL_EN
        S_MUL_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            {aluout_hi, aluout} <= w_acc_next;
            carry   <= 1'b0;
            zero    <= (w_acc_next == 8'd0);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_core_seq.sv
`default_nettype none
// =============================================================================
// Module  : tb_alu_core_seq
// Brief   : Self-checking bench for alu_core_seq (vector table, random ops
//           against a reference model, MUL/busy, reset and key corner cases).
// Revision: 1.0 - initial release
// =============================================================================
module tb_alu_core_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_a, sw_b;
  logic [2:0] op;
  logic       key_load_a, key_load_b, key_exec;
  logic [3:0] aluout, aluout_hi;
  logic       carry, zero, err, busy, done;

  int checks = 0;
  int errors = 0;

  alu_core_seq #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sw_a(sw_a), .sw_b(sw_b), .op(op),
    .key_load_a(key_load_a), .key_load_b(key_load_b), .key_exec(key_exec),
    .aluout(aluout), .aluout_hi(aluout_hi), .carry(carry), .zero(zero),
    .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a, b;
    logic [2:0] o;
    logic [3:0] lo, hi;
    logic       c, z;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model straight from the operation definitions.
  task automatic model(input int a, input int b, input int o,
                       output int lo, output int hi, output int c, output int z, output int e);
    int r;
    r = 0; hi = 0; c = 0; e = 0;
    case (o)
      0: begin r = a + b; c = (r > 15) ? 1 : 0; r = r % 16; end
      1: begin c = (a < b) ? 1 : 0; r = (a - b + 16) % 16; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin c = (a >= 8) ? 1 : 0; r = (a * 2) % 16; end
      default: begin
`ifdef ALU_MUL_EN
        r = (a * b) % 16; hi = (a * b) / 16;
`else
        r = 0; e = 1;
`endif
      end
    endcase
    lo = r;
    z  = (r == 0 && hi == 0) ? 1 : 0;
  endtask

  task automatic load(input bit to_b, input logic [3:0] v);
    if (to_b) begin sw_b = v; key_load_b = 1'b0; end
    else      begin sw_a = v; key_load_a = 1'b0; end
    tick(4);
    key_load_a = 1'b1;
    key_load_b = 1'b1;
    tick(4);
  endtask

  // Press exec and wait (bounded) until a fresh result is flagged by done.
  task automatic run_exec(input logic [2:0] o, output int bc);
    bit seen_clear, fin;
    op = o; key_exec = 1'b0; bc = 0; seen_clear = 0; fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      if (i == 2) key_exec = 1'b1;
      if (busy) bc++;
      if (!done) seen_clear = 1;
      else if (seen_clear && i >= 2) fin = 1;
    end
    key_exec = 1'b1;
    if (!fin) check("exec_timeout", 8'd0, 8'd1);
    tick(3);
  endtask

  task automatic do_op(input string name, input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
    int lo, hi, c, z, e, bc;
    model(a, b, o, lo, hi, c, z, e);
    load(1'b0, a);
    load(1'b1, b);
    run_exec(o, bc);
    check({name, "_aluout"}, aluout, lo[7:0]);
    check({name, "_aluout_hi"}, aluout_hi, hi[7:0]);
    check({name, "_carry"}, carry, c[7:0]);
    check({name, "_zero"}, zero, z[7:0]);
    check({name, "_err"}, err, e[7:0]);
    check({name, "_done"}, done, 8'd1);
    check({name, "_busy"}, busy, 8'd0);
`ifdef ALU_MUL_EN
    if (o == 3'b111) check({name, "_mul_busy_cycles"}, bc[7:0], 8'd4);
`endif
  endtask

  initial begin
    vec_t vt[10];
    int   bc, lo, hi, c, z, e;
    bit   disturbed, pressed, fin;
    int   pi;

    vt[0] = '{4'd9,  4'd8,  3'd0, 4'd1,  4'd0, 1'b1, 1'b0};
    vt[1] = '{4'd3,  4'd5,  3'd1, 4'd14, 4'd0, 1'b1, 1'b0};
    vt[2] = '{4'd5,  4'd5,  3'd1, 4'd0,  4'd0, 1'b0, 1'b1};
    vt[3] = '{4'd12, 4'd10, 3'd2, 4'd8,  4'd0, 1'b0, 1'b0};
    vt[4] = '{4'd12, 4'd3,  3'd3, 4'd15, 4'd0, 1'b0, 1'b0};
    vt[5] = '{4'd15, 4'd15, 3'd4, 4'd0,  4'd0, 1'b0, 1'b1};
    vt[6] = '{4'd6,  4'd0,  3'd5, 4'd9,  4'd0, 1'b0, 1'b0};
    vt[7] = '{4'd9,  4'd0,  3'd6, 4'd2,  4'd0, 1'b1, 1'b0};
    vt[8] = '{4'd4,  4'd0,  3'd6, 4'd8,  4'd0, 1'b0, 1'b0};
    vt[9] = '{4'd15, 4'd1,  3'd0, 4'd0,  4'd0, 1'b1, 1'b1};

    rst_n = 1'b0; sw_a = 4'd0; sw_b = 4'd0; op = 3'd0;
    key_load_a = 1'b1; key_load_b = 1'b1; key_exec = 1'b1;
    tick(3);
    check("rst_aluout", aluout, 8'd0);
    check("rst_aluout_hi", aluout_hi, 8'd0);
    check("rst_carry", carry, 8'd0);
    check("rst_zero", zero, 8'd1);
    check("rst_err", err, 8'd0);
    check("rst_busy", busy, 8'd0);
    check("rst_done", done, 8'd0);
    rst_n = 1'b1;
    tick(4);

    for (int i = 0; i < 10; i++) begin
      load(1'b0, vt[i].a);
      load(1'b1, vt[i].b);
      run_exec(vt[i].o, bc);
      check($sformatf("vec%0d_aluout", i), aluout, vt[i].lo);
      check($sformatf("vec%0d_aluout_hi", i), aluout_hi, vt[i].hi);
      check($sformatf("vec%0d_carry", i), carry, vt[i].c);
      check($sformatf("vec%0d_zero", i), zero, vt[i].z);
      check($sformatf("vec%0d_done", i), done, 8'd1);
    end

    // Load and exec falling together: A changes, nothing executes (A=15, B=1 before).
    sw_a = 4'd7; op = 3'd0; key_load_a = 1'b0; key_exec = 1'b0;
    disturbed = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || !done) disturbed = 1;
    end
    key_load_a = 1'b1; key_exec = 1'b1;
    tick(4);
    check("same_cycle_no_exec", {7'd0, disturbed}, 8'd0);
    check("same_cycle_aluout_kept", aluout, 8'd0);
    check("same_cycle_done_kept", done, 8'd1);
    run_exec(3'd0, bc);
    check("same_cycle_a_loaded", aluout, 8'd8);

    for (int i = 0; i < 24; i++) begin
      do_op("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    end

`ifdef ALU_MUL_EN
    // MUL 15*15 with load and exec presses landing while busy.
    load(1'b0, 4'd15);
    load(1'b1, 4'd15);
    op = 3'd7; key_exec = 1'b0; bc = 0; pressed = 0; fin = 0; pi = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      if (i == 1) key_exec = 1'b1;
      if (busy) begin
        bc++;
        if (!pressed) begin
          pressed = 1; pi = i; sw_a = 4'd2; op = 3'd0;
          key_load_a = 1'b0; key_exec = 1'b0;
        end
      end
      if (pressed && i == pi + 3) begin key_load_a = 1'b1; key_exec = 1'b1; end
      if (pressed && done && !busy && i > pi + 3) fin = 1;
    end
    key_load_a = 1'b1; key_exec = 1'b1;
    if (!fin) check("mul_timeout", 8'd0, 8'd1);
    tick(2);
    check("mul_busy_cycles", bc[7:0], 8'd4);
    check("mul_aluout_hi", aluout_hi, 8'd14);
    check("mul_aluout", aluout, 8'd1);
    check("mul_done", done, 8'd1);
    check("mul_busy_after", busy, 8'd0);
    check("mul_err", err, 8'd0);
    tick(4);
    run_exec(3'd0, bc);
    model(15, 15, 0, lo, hi, c, z, e);
    check("mul_a_unchanged", aluout, lo[7:0]);
    check("mul_a_unchanged_carry", carry, c[7:0]);
`else
    do_op("nomul", 4'd6, 4'd3, 3'd7);
    check("nomul_err_set", err, 8'd1);
    check("nomul_aluout", aluout, 8'd0);
    run_exec(3'd0, bc);
    check("nomul_err_cleared", err, 8'd0);
    check("nomul_add_result", aluout, 8'd9);
`endif

    // Reset in the middle of an operation, with exec held low through release.
    load(1'b0, 4'd15);
    load(1'b1, 4'd15);
    op = 3'd7; key_exec = 1'b0; fin = 0;
    for (int i = 0; i < 20 && !fin; i++) begin
      @(negedge clk);
      if (busy) fin = 1;
    end
    if (!fin) check("midrst_busy_timeout", 8'd0, 8'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_aluout", aluout, 8'd0);
    check("midrst_aluout_hi", aluout_hi, 8'd0);
    check("midrst_carry", carry, 8'd0);
    check("midrst_zero", zero, 8'd1);
    check("midrst_err", err, 8'd0);
    check("midrst_busy", busy, 8'd0);
    check("midrst_done", done, 8'd0);
    tick(2);
    rst_n = 1'b1;
    disturbed = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || done) disturbed = 1;
    end
    check("held_key_no_pulse", {7'd0, disturbed}, 8'd0);
    check("after_rst_aluout", aluout, 8'd0);
    key_exec = 1'b1;
    tick(4);
    run_exec(3'd0, bc);
    check("after_rst_idle_add", aluout, 8'd0);
    check("after_rst_idle_zero", zero, 8'd1);
    check("after_rst_idle_done", done, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_core_seq.md
ALU_CORE_SEQ -- requirements
Module: alu_core_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchroniser flops per key input (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port sw_a, input, 4, the operand A switches.
REQ-005 SHALL have port sw_b, input, 4, the operand B switches.
REQ-006 SHALL have port op, input, 3, the operation select, sampled on exec.
REQ-007 SHALL have ports key_load_a, key_load_b, key_exec, input, 1 each, active-low raw pushbuttons.
REQ-008 SHALL have port aluout, output, 4, the registered result nibble that feeds the 7-segment converter.
REQ-009 SHALL have port aluout_hi, output, 4, the registered high nibble, nonzero only for MUL.
REQ-010 SHALL have ports carry, zero, err, busy, done, output, 1 each, registered status flags.

Function
REQ-011 SHALL pass each key through SYNC_STAGES flops and detect its 1->0 edge as a one-cycle pulse.
REQ-012 SHALL load sw_a into the A register on a load_a pulse, and sw_b into the B register on a load_b pulse, only in state IDLE or DONE.
REQ-013 SHALL implement the states IDLE, EXEC, MUL_RUN and DONE.
REQ-014 SHALL, on an exec pulse in IDLE or DONE, latch op and move to EXEC for single-cycle ops, or to MUL_RUN for op 3'b111.
REQ-015 SHALL define the op encoding as: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL A by 1, 111 MUL.
REQ-016 SHALL, in EXEC, register the result and flags, then go to DONE; aluout is valid 1 cycle after the exec pulse.
REQ-017 SHALL compute ADD as {carry,aluout}=A+B (5 bits), and SUB with carry=1 on borrow (A<B) and aluout=(A-B) mod 16.
REQ-018 SHALL set carry=A[3] for SHL, and carry=0 for the logic ops.
REQ-019 SHALL set zero=1 iff the full result is zero, i.e. {aluout_hi,aluout}==0 for MUL and aluout==0 otherwise.
REQ-020 SHALL implement MUL as shift-add over exactly 4 cycles in MUL_RUN, with busy=1 throughout, then go to DONE with the 8-bit product on {aluout_hi,aluout}.
REQ-021 SHALL hold aluout_hi=0 for every non-MUL op.
REQ-022 SHALL hold done=1 in DONE; it clears on the next exec pulse.
REQ-023 SHALL ignore load and exec pulses while busy, with no queuing.
REQ-024 SHALL, when load and exec pulse in the same cycle, perform the load and ignore the exec.
REQ-025 SHALL keep aluout and the flags stable until the next result is registered.

Reset
REQ-026 SHALL, while rst_n=0, immediately force: state IDLE; A, B and op to 0; aluout, aluout_hi, carry and err to 0; zero=1; busy=0; done=0; all synchronisers to 1 (released).
REQ-027 SHALL, when reset is asserted mid-MUL, abort the operation with no partial result visible after release.
REQ-028 SHALL not produce a key pulse from a key held low through reset release until that key goes high and then low again.

Configuration
REQ-029 SHALL, with ALU_MUL_EN defined, implement MUL and MUL_RUN as specified.
REQ-030 SHALL, without ALU_MUL_EN, treat op 111 as single-cycle with aluout=0, aluout_hi=0, carry=0, zero=1 and err=1; MUL_RUN shall not exist.
REQ-031 SHALL have err cleared by the next exec pulse, and err SHALL always be 0 when ALU_MUL_EN is defined.

Verification
REQ-032 SHALL verify: A=9, B=8, op=000 -> aluout=1, carry=1, zero=0, done=1 one cycle after the exec pulse.
REQ-033 SHALL verify: A=3, B=5, op=001 -> aluout=14, carry=1; then A=5, B=5 -> aluout=0, zero=1, carry=0.
REQ-034 SHALL verify, with ALU_MUL_EN: A=15, B=15, op=111 -> busy high for 4 cycles, then aluout_hi=14, aluout=1, done=1; exec and load pulses during busy have no effect.
REQ-035 SHALL verify, without ALU_MUL_EN: op=111 -> err=1, aluout=0 one cycle after exec; a following ADD clears err.
REQ-036 SHALL verify: rst_n pulsed low during cycle 2 of MUL -> all outputs take their reset values asynchronously, and the state is IDLE after release.
REQ-037 SHALL verify: key_load_a and key_exec falling in the same cycle -> A updated, no execution, done unchanged.
